// File: rtl/count_monitor.sv
// Watches the output of a free-running 4-bit up-counter and flags sequence slips.
// Tracks mismatches and accepted 15->0 wraps in saturating statistics counters.
module count_monitor (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       sample_en,
  input  logic [3:0] count_in,
  output logic       locked,
  output logic       err,
  output logic [3:0] expected,
  output logic [7:0] err_count,
  output logic [7:0] wrap_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    SLIP   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       locked_q, locked_d;
  logic       err_q, err_d;
  logic [3:0] expected_q, expected_d;
  logic [7:0] err_count_q, err_count_d;
  logic [7:0] wrap_count_q, wrap_count_d;
  logic [1:0] good_run_q, good_run_d;

  logic       match;
  logic [7:0] err_count_inc;
  logic [7:0] wrap_count_inc;

  assign match          = (count_in == expected_q);
  assign err_count_inc  = (err_count_q  == 8'hFF) ? err_count_q  : err_count_q  + 8'd1;
  assign wrap_count_inc = (wrap_count_q == 8'hFF) ? wrap_count_q : wrap_count_q + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      expected_q   <= 4'h0;
      err_count_q  <= 8'h00;
      wrap_count_q <= 8'h00;
      good_run_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
      expected_q   <= expected_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
      good_run_q   <= good_run_d;
    end
  end

  // err is a pulse, so it defaults low every cycle; everything else holds.
  always_comb begin
    state_d      = state_q;
    err_d        = 1'b0;
    expected_d   = expected_q;
    err_count_d  = err_count_q;
    wrap_count_d = wrap_count_q;
    good_run_d   = good_run_q;

    if (clr) begin
      state_d      = IDLE;
      expected_d   = 4'h0;
      err_count_d  = 8'h00;
      wrap_count_d = 8'h00;
      good_run_d   = 2'd0;
    end else if (sample_en) begin
      unique case (state_q)
        IDLE: begin
          expected_d = count_in + 4'd1;
          state_d    = LOCKED;
        end
        LOCKED: begin
          if (match) begin
            expected_d = expected_q + 4'd1;
            if (count_in == 4'hF) wrap_count_d = wrap_count_inc;
          end else begin
            err_d       = 1'b1;
            err_count_d = err_count_inc;
            expected_d  = count_in + 4'd1;
            good_run_d  = 2'd0;
            state_d     = SLIP;
          end
        end
        SLIP: begin
          if (match) begin
            expected_d = expected_q + 4'd1;
            if (count_in == 4'hF) wrap_count_d = wrap_count_inc;
            // One prior match plus this one makes two in a row: relock.
            if (good_run_q == 2'd1) begin
              good_run_d = 2'd0;
              state_d    = LOCKED;
            end else begin
              good_run_d = good_run_q + 2'd1;
            end
          end else begin
            err_d       = 1'b1;
            err_count_d = err_count_inc;
            expected_d  = count_in + 4'd1;
            good_run_d  = 2'd0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  assign locked     = locked_q;
  assign err        = err_q;
  assign expected   = expected_q;
  assign err_count  = err_count_q;
  assign wrap_count = wrap_count_q;

endmodule
